// File: rtl/lvds_rx_lock_ctrl.sv
// LVDS RX lock sequencer: drives deserializer io_reset, locks on frame geometry, gates video (optional LVDS_RX_STATS_EN counters).
// Latency: video out is registered, 1 cycle after input; no backpressure, the pixel stream is free-running.
module lvds_rx_lock_ctrl #(
  parameter int P_H_ACTIVE     = 1920,
  parameter int P_V_ACTIVE     = 1080,
  parameter int P_LOCK_FRAMES  = 3,
  parameter int P_LOSS_FRAMES  = 2,
  parameter int P_RETRY_FRAMES = 8,
  parameter int P_RST_CYCLES   = 16,
  parameter int P_VS_TIMEOUT   = 4_000_000
) (
  input  logic        i_rst_n,
  input  logic        w_pixel_clk,
  input  logic        i_vs,
  input  logic        i_hs,
  input  logic        i_de,
  input  logic [23:0] i_data,
  output logic        o_io_reset,
  output logic        o_locked,
  output logic [2:0]  o_state,
  output logic        o_vs,
  output logic        o_hs,
  output logic        o_de,
  output logic [23:0] o_data,
  output logic [11:0] o_h_meas,
  output logic [11:0] o_v_meas,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int TW = $clog2(P_VS_TIMEOUT + 1);
  localparam int RW = $clog2(P_RST_CYCLES + 1);

  localparam logic [11:0]   H_ACT    = 12'(P_H_ACTIVE);
  localparam logic [11:0]   V_ACT    = 12'(P_V_ACTIVE);
  localparam logic [15:0]   LOCK_N   = 16'(P_LOCK_FRAMES);
  localparam logic [15:0]   LOSS_N   = 16'(P_LOSS_FRAMES);
  localparam logic [15:0]   RETRY_N  = 16'(P_RETRY_FRAMES);
  localparam logic [TW-1:0] TO_LAST  = TW'(P_VS_TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(P_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RST_IO  = 3'd0,
    ST_SYNC    = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3
  } state_t;

  state_t state, state_next;

  logic          vs_d, de_d;
  logic          vs_rise, line_end;
  logic [11:0]   h_cnt, v_cnt, v_cnt_close;
  logic          frame_bad, frame_bad_close, frame_good;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic [RW-1:0] rst_cnt;
  logic          rst_done;
  logic [15:0]   good_cnt, bad_cnt, good_cnt_next, bad_cnt_next;
  logic [15:0]   good_inc, bad_inc;
  logic          out_en, out_en_next;

  assign vs_rise  = i_vs & ~vs_d;
  assign line_end = ~i_de & de_d;

  // A line ending in the vs_rise cycle still belongs to the frame being closed.
  assign v_cnt_close     = (line_end && v_cnt != 12'hFFF) ? v_cnt + 12'd1 : v_cnt;
  assign frame_bad_close = frame_bad | (line_end & (h_cnt != H_ACT));
  assign frame_good      = (v_cnt_close == V_ACT) & ~frame_bad_close;

  assign timeout  = (state != ST_RST_IO) && (to_cnt == TO_LAST);
  assign rst_done = (rst_cnt == RST_LAST);
  assign good_inc = good_cnt + 16'd1;
  assign bad_inc  = bad_cnt + 16'd1;

  always_ff @(posedge w_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_RST_IO;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
      bad_cnt  <= bad_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    bad_cnt_next  = bad_cnt;
    case (state)
      ST_RST_IO: begin
        good_cnt_next = '0;
        bad_cnt_next  = '0;
        if (rst_done) state_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (timeout) begin
          state_next = ST_RST_IO;
        end else if (vs_rise) begin
          state_next    = ST_MEASURE;
          good_cnt_next = '0;
          bad_cnt_next  = '0;
        end
      end
      ST_MEASURE: begin
        if (timeout) begin
          state_next = ST_RST_IO;
        end else if (vs_rise) begin
          if (frame_good) begin
            good_cnt_next = good_inc;
            bad_cnt_next  = '0;
            if (good_inc >= LOCK_N) state_next = ST_LOCKED;
          end else begin
            good_cnt_next = '0;
            bad_cnt_next  = bad_inc;
            if (bad_inc >= RETRY_N) state_next = ST_RST_IO;
          end
        end
      end
      ST_LOCKED: begin
        if (timeout) begin
          state_next = ST_RST_IO;
        end else if (vs_rise) begin
          if (frame_good) begin
            bad_cnt_next = '0;
          end else begin
            bad_cnt_next = bad_inc;
            if (bad_inc >= LOSS_N) state_next = ST_RST_IO;
          end
        end
      end
      default: state_next = ST_RST_IO;
    endcase
  end

  always_comb begin
    o_io_reset = (state == ST_RST_IO);
    o_locked   = (state == ST_LOCKED);
    o_state    = state;
  end

  always_ff @(posedge w_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      rst_cnt <= (state == ST_RST_IO) ? rst_cnt + 1'b1 : '0;
      to_cnt  <= (state == ST_RST_IO || vs_rise) ? '0 : to_cnt + 1'b1;
    end
  end

  always_ff @(posedge w_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_bad <= 1'b0;
      o_h_meas  <= '0;
      o_v_meas  <= '0;
    end else begin
      vs_d <= i_vs;
      de_d <= i_de;
      if (state == ST_RST_IO) begin
        h_cnt     <= '0;
        v_cnt     <= '0;
        frame_bad <= 1'b0;
      end else begin
        if (line_end) begin
          o_h_meas <= h_cnt;
          h_cnt    <= '0;
        end else if (i_de && h_cnt != 12'hFFF) begin
          h_cnt <= h_cnt + 12'd1;
        end
        if (vs_rise) begin
          o_v_meas  <= v_cnt_close;
          v_cnt     <= '0;
          frame_bad <= 1'b0;
        end else begin
          v_cnt     <= v_cnt_close;
          frame_bad <= frame_bad_close;
        end
      end
    end
  end

  // Passing opens only on a VS edge, so downstream never sees a partial frame.
  assign out_en_next = (state_next == ST_LOCKED) && (vs_rise || out_en);

  always_ff @(posedge w_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_en <= 1'b0;
      o_vs   <= 1'b0;
      o_hs   <= 1'b0;
      o_de   <= 1'b0;
      o_data <= '0;
    end else begin
      out_en <= out_en_next;
      o_vs   <= out_en_next & i_vs;
      o_hs   <= out_en_next & i_hs;
      o_de   <= out_en_next & i_de;
      o_data <= out_en_next ? i_data : '0;
    end
  end

`ifdef LVDS_RX_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;

  // Statistics survive RST_IO re-syncs; only the block reset clears them.
  always_ff @(posedge w_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (vs_rise && (state == ST_MEASURE || state == ST_LOCKED)) begin
      if (frame_good)
        frame_cnt <= frame_cnt + 32'd1;
      else if (err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt;
  assign o_err_cnt   = err_cnt;
`else
  assign o_frame_cnt = '0;
  assign o_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_lvds_rx_lock_ctrl.sv
// Bench for lvds_rx_lock_ctrl: frame-level reference model checked every cycle, plus directed literal checks.
module tb_lvds_rx_lock_ctrl;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int LOCK  = 3;
  localparam int LOSS  = 2;
  localparam int RETRY = 8;
  localparam int RSTC  = 16;
  localparam int TO    = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;
  logic [23:0] i_data = '0;
  logic        o_io_reset, o_locked, o_vs, o_hs, o_de;
  logic [2:0]  o_state;
  logic [23:0] o_data;
  logic [11:0] o_h_meas, o_v_meas;
  logic [31:0] o_frame_cnt;
  logic [15:0] o_err_cnt;

  lvds_rx_lock_ctrl #(
    .P_H_ACTIVE(H), .P_V_ACTIVE(V), .P_LOCK_FRAMES(LOCK), .P_LOSS_FRAMES(LOSS),
    .P_RETRY_FRAMES(RETRY), .P_RST_CYCLES(RSTC), .P_VS_TIMEOUT(TO)
  ) dut (
    .i_rst_n(rst_n), .w_pixel_clk(clk),
    .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de), .i_data(i_data),
    .o_io_reset(o_io_reset), .o_locked(o_locked), .o_state(o_state),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_data(o_data),
    .o_h_meas(o_h_meas), .o_v_meas(o_v_meas),
    .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int pix = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: state as "mode", frame tallies as plain integers.
  int          m_st, nst, m_rst_left, m_hlen, m_lines, m_idle, m_g, m_b;
  bit          m_pvs, m_pde, m_bad, m_pass, vr, le, tmo, good;
  logic        e_vs, e_hs, e_de;
  logic [23:0] e_data;
  int          e_hm, e_vm;
  logic [31:0] e_fc;
  logic [15:0] e_ec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_rst_left = RSTC; m_pvs = 0; m_pde = 0; m_hlen = 0; m_lines = 0;
      m_bad = 0; m_idle = 0; m_g = 0; m_b = 0; m_pass = 0;
      e_vs = 0; e_hs = 0; e_de = 0; e_data = '0; e_hm = 0; e_vm = 0; e_fc = '0; e_ec = '0;
    end else begin
      vr  = i_vs && !m_pvs;
      le  = !i_de && m_pde;
      nst = m_st;
      if (m_st == 0) begin
        m_rst_left--;
        if (m_rst_left == 0) nst = 1;
        m_hlen = 0; m_lines = 0; m_bad = 0; m_idle = 0;
      end else begin
        tmo = (m_idle + 1 >= TO);
        if (le) begin
          e_hm = m_hlen;
          if (m_hlen != H) m_bad = 1;
          m_lines = (m_lines < 4095) ? m_lines + 1 : 4095;
          m_hlen = 0;
        end else if (i_de && m_hlen < 4095) begin
          m_hlen++;
        end
        good = (m_lines == V) && !m_bad;
        if (vr) begin
          e_vm = m_lines;
          m_lines = 0;
          m_bad = 0;
`ifdef LVDS_RX_STATS_EN
          if (m_st == 2 || m_st == 3) begin
            if (good) e_fc = e_fc + 1;
            else if (e_ec != 16'hFFFF) e_ec = e_ec + 1;
          end
`endif
        end
        m_idle = vr ? 0 : m_idle + 1;
        if (tmo) nst = 0;
        else if (vr) begin
          if (m_st == 1) begin
            nst = 2; m_g = 0; m_b = 0;
          end else if (m_st == 2) begin
            if (good) begin m_g++; m_b = 0; if (m_g >= LOCK) nst = 3; end
            else begin m_g = 0; m_b++; if (m_b >= RETRY) nst = 0; end
          end else if (m_st == 3) begin
            if (good) m_b = 0;
            else begin m_b++; if (m_b >= LOSS) nst = 0; end
          end
        end
      end
      if (nst == 0 && m_st != 0) begin
        m_rst_left = RSTC; m_g = 0; m_b = 0;
      end
      m_pass = (nst == 3) && (vr || m_pass);
      e_vs   = m_pass & i_vs;
      e_hs   = m_pass & i_hs;
      e_de   = m_pass & i_de;
      e_data = m_pass ? i_data : 24'h0;
      m_pvs  = i_vs;
      m_pde  = i_de;
      m_st   = nst;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("io_reset", 32'(o_io_reset), 32'(m_st == 0));
    chk("locked",   32'(o_locked),   32'(m_st == 3));
    chk("state",    32'(o_state),    32'(m_st));
    chk("vs_out",   32'(o_vs),       32'(e_vs));
    chk("hs_out",   32'(o_hs),       32'(e_hs));
    chk("de_out",   32'(o_de),       32'(e_de));
    chk("data_out", 32'(o_data),     32'(e_data));
    chk("h_meas",   32'(o_h_meas),   32'(e_hm));
    chk("v_meas",   32'(o_v_meas),   32'(e_vm));
    chk("frame_cnt", o_frame_cnt,    e_fc);
    chk("err_cnt",  32'(o_err_cnt),  32'(e_ec));
  end

  task automatic drive(input logic vs, input logic hs, input logic de);
    @(negedge clk);
    i_vs   = vs;
    i_hs   = hs;
    i_de   = de;
    i_data = 24'(pix * 3 + 1);
    pix++;
  endtask

  task automatic frame_head();
    drive(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_rest(input int nlines, input int short_line, input int short_len);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      repeat ((l == short_line) ? short_len : H) drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int nlines);
    frame_head();
    frame_rest(nlines, -1, 0);
  endtask

  task automatic count_io_reset(input string name);
    int n;
    n = 0;
    while (o_io_reset === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n), 32'(RSTC));
  endtask

  int exp_lock_fc, exp_one_err, t0, n;

  initial begin
`ifdef LVDS_RX_STATS_EN
    exp_lock_fc = 3;
    exp_one_err = 1;
`else
    exp_lock_fc = 0;
    exp_one_err = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("por_io_reset", 32'(o_io_reset), 32'd1);
    chk("por_state",    32'(o_state),    32'd0);
    chk("por_vs_out",   32'(o_vs),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_io_reset("por_io_reset_len");
    chk("por_sync_state", 32'(o_state), 32'd1);

    // Clean frames: the first VS only leaves SYNC, three good frames then lock.
    frame(V);
    frame(V);
    frame_head();
    chk("pre_lock_locked", 32'(o_locked), 32'd0);
    frame_rest(V, -1, 0);
    frame_head();
    chk("lock_locked",    32'(o_locked),    32'd1);
    chk("lock_vs_passed", 32'(o_vs),        32'd1);
    chk("lock_frame_cnt", o_frame_cnt,      32'(exp_lock_fc));
    chk("lock_h_meas",    32'(o_h_meas),    32'd8);
    chk("lock_v_meas",    32'(o_v_meas),    32'd4);
    frame_rest(V, -1, 0);

    // One short line holds lock; a following 3-line frame drops it.
    frame_head();
    frame_rest(V, 1, 7);
    frame_head();
    chk("bad1_err_cnt", 32'(o_err_cnt), 32'(exp_one_err));
    chk("bad1_locked",  32'(o_locked),  32'd1);
    chk("bad1_h_meas",  32'(o_h_meas),  32'd8);
    frame_rest(V - 1, -1, 0);
    frame_head();
    chk("bad2_locked",   32'(o_locked),   32'd0);
    chk("bad2_vs_out",   32'(o_vs),       32'd0);
    chk("bad2_io_reset", 32'(o_io_reset), 32'd1);
    chk("bad2_v_meas",   32'(o_v_meas),   32'd3);
    count_io_reset("loss_io_reset_len");
    frame_rest(V, -1, 0);

    // Relock, then starve VS to force the timeout.
    frame(V);
    frame(V);
    frame(V);
    frame_head();
    chk("relock_locked", 32'(o_locked), 32'd1);
    t0 = cyc;
    frame_rest(V, -1, 0);
    n = 0;
    while (o_state !== 3'd0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("vs_timeout_cycles", 32'(cyc - t0), 32'(TO));
    count_io_reset("timeout_io_reset_len");

    // Relock, then async reset in the middle of a locked frame.
    frame(V);
    frame(V);
    frame(V);
    frame_head();
    chk("relock2_locked", 32'(o_locked), 32'd1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_io_reset",  32'(o_io_reset),  32'd1);
    chk("arst_locked",    32'(o_locked),    32'd0);
    chk("arst_de_out",    32'(o_de),        32'd0);
    chk("arst_data_out",  32'(o_data),      32'd0);
    chk("arst_h_meas",    32'(o_h_meas),    32'd0);
    chk("arst_frame_cnt", o_frame_cnt,      32'd0);
    @(negedge clk);
    i_de = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_io_reset("arst_io_reset_len");
    frame(V);
    frame(V);
    frame_head();
    chk("arst_pre_lock", 32'(o_locked), 32'd0);
    frame_rest(V, -1, 0);
    frame_head();
    chk("arst_relock",     32'(o_locked),  32'd1);
    chk("arst_relock_fc",  o_frame_cnt,    32'(exp_lock_fc));
    frame_rest(V, -1, 0);
    frame(V);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1);
  end

endmodule
